// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-wide instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES  = 32'd4;
    localparam logic [31:0] BUNDLE_BYTES = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr_a;
        logic [31:0] instr_b;
        logic        valid_b;
    } fetch_bundle_t;

    // A bundle starting on the upper word of an 8-byte pair carries only one instruction.
    function automatic logic [31:0] fetch_step(input logic upper_word);
        return upper_word ? INSTR_BYTES : BUNDLE_BYTES;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Selects the PC to issue this cycle and derives the port-B and next-sequential addresses.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    input  logic [31:0] pc_f2,
    input  logic [31:0] pc_next,
    output logic [31:0] issue_pc,
    output logic [31:0] addr_b,
    output logic [31:0] seq_pc
);

    // Redirect beats a stalled bundle, which beats the sequential stream.
    always_comb begin
        if (rst) begin
            issue_pc = RESET_PC;
        end else if (redirect_valid) begin
            issue_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (hold) begin
            issue_pc = pc_f2;
        end else begin
            issue_pc = pc_next;
        end
    end

    assign addr_b = issue_pc + INSTR_BYTES;
    assign seq_pc = issue_pc + fetch_step(issue_pc[2]);

endmodule

// File: rtl/fetch_controller.sv
// Two-wide fetch sequencer for a dual-port synchronous-read imem; backpressure re-reads the held PC.
// Define FETCH_RANGE_CHECK_EN to add the out_fault port and clip slot B at the end of memory.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr_a,
    output logic [31:0] imem_addr_b,
    input  logic [31:0] imem_data_a,
    input  logic [31:0] imem_data_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr_a,
    output logic [31:0] out_instr_b,
    output logic        out_valid_b
`ifdef FETCH_RANGE_CHECK_EN
    ,
    output logic        out_fault
`endif
);

    logic [31:0]   pc_next_q;
    logic [31:0]   pc_f2_q;
    logic          f2_valid_q;
    fetch_state_e  state_q;

    logic [31:0]   issue_pc;
    logic [31:0]   seq_pc;
    logic          hold;
    logic          issue;
    fetch_bundle_t bundle;

    assign hold  = f2_valid_q && !out_ready;
    assign issue = redirect_valid || hold || fetch_en;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .hold          (hold),
        .pc_f2         (pc_f2_q),
        .pc_next       (pc_next_q),
        .issue_pc      (issue_pc),
        .addr_b        (imem_addr_b),
        .seq_pc        (seq_pc)
    );

    assign imem_addr_a = issue_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            f2_valid_q <= 1'b0;
            pc_next_q  <= RESET_PC;
            pc_f2_q    <= RESET_PC;
        end else begin
            pc_f2_q    <= issue_pc;
            f2_valid_q <= issue;
            if (issue) begin
                pc_next_q <= seq_pc;
            end
            case (state_q)
                BOOT:    state_q <= issue ? RUN : HALT;
                RUN:     if (!issue) state_q <= HALT;
                HALT:    if (issue) state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

    // The word on imem_data this cycle belongs to pc_f2_q; a redirect kills it before handshake.
    always_comb begin
        bundle.pc      = pc_f2_q;
        bundle.instr_a = imem_data_a;
        bundle.instr_b = imem_data_b;
        bundle.valid_b = !pc_f2_q[2];
`ifdef FETCH_RANGE_CHECK_EN
        if (({1'b0, pc_f2_q} + 33'd4) >= 33'(IMEM_BYTES)) begin
            bundle.valid_b = 1'b0;
        end
`endif
    end

    assign out_valid   = f2_valid_q && !redirect_valid && !rst;
    assign out_pc      = bundle.pc;
    assign out_instr_a = bundle.instr_a;
    assign out_instr_b = bundle.instr_b;
    assign out_valid_b = out_valid && bundle.valid_b;

`ifdef FETCH_RANGE_CHECK_EN
    assign out_fault = out_valid && (pc_f2_q >= IMEM_BYTES);
`else
    logic unused_cfg;
    assign unused_cfg = (IMEM_BYTES == 0);
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed scoreboard bench for fetch_controller with a behavioural 1-cycle-latency imem.
module tb_fetch_controller;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr_a;
    logic [31:0] imem_addr_b;
    logic [31:0] imem_data_a;
    logic [31:0] imem_data_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr_a;
    logic [31:0] out_instr_b;
    logic        out_valid_b;
`ifdef FETCH_RANGE_CHECK_EN
    logic        out_fault;
`endif

    int checks = 0;
    int errors = 0;
    fetch_bundle_t sb[$];

    fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(16384)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr_a   (imem_addr_a),
        .imem_addr_b   (imem_addr_b),
        .imem_data_a   (imem_data_a),
        .imem_data_b   (imem_data_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr_a   (out_instr_a),
        .out_instr_b   (out_instr_b),
        .out_valid_b   (out_valid_b)
`ifdef FETCH_RANGE_CHECK_EN
        ,
        .out_fault     (out_fault)
`endif
    );

    always #5 clk = ~clk;

    // Every address maps to a distinct word so a wrong PC shows up in the data.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} + 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        imem_data_a <= mem_word(imem_addr_a);
        imem_data_b <= mem_word(imem_addr_b);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectBundle(input logic [31:0] pc, input logic vb);
        fetch_bundle_t b;
        b.pc      = pc;
        b.instr_a = mem_word(pc);
        b.instr_b = mem_word(pc + 32'd4);
        b.valid_b = vb;
        sb.push_back(b);
    endtask

    task automatic applyStimulus(input logic r, input logic fe, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst            = r;
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // One clock: drive inputs, check out_valid, and retire a bundle on handshake.
    task automatic cycle(input logic r, input logic fe, input logic rdy,
                         input logic rv, input logic [31:0] rpc, input logic exp_valid);
        fetch_bundle_t exp;
        applyStimulus(r, fe, rdy, rv, rpc);
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checkOutput("bundle_pc", out_pc, exp.pc);
                checkOutput("bundle_instr_a", out_instr_a, exp.instr_a);
                checkOutput("bundle_valid_b", 32'(out_valid_b), 32'(exp.valid_b));
                if (exp.valid_b) begin
                    checkOutput("bundle_instr_b", out_instr_b, exp.instr_b);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] fetch_controller directed sequence starting");
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_addr_a", imem_addr_a, 32'h0);
        checkOutput("rst_addr_b", imem_addr_b, 32'h4);
        checkOutput("rst_valid_b", 32'(out_valid_b), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Streaming from reset
        expectBundle(32'h00, 1'b1);
        expectBundle(32'h08, 1'b1);
        expectBundle(32'h10, 1'b1);
        expectBundle(32'h18, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("boot_addr_a", imem_addr_a, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stream_addr_a1", imem_addr_a, 32'h8);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stream_addr_a2", imem_addr_a, 32'h10);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Backpressure at 0x20 for three cycles
        expectBundle(32'h20, 1'b1);
        expectBundle(32'h28, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("hold_addr_a", imem_addr_a, 32'h20);
            checkOutput("hold_pc", out_pc, 32'h20);
            checkOutput("hold_instr_a", out_instr_a, mem_word(32'h20));
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("release_addr_a", imem_addr_a, 32'h28);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect while streaming; low target bits are ignored
        expectBundle(32'h104, 1'b0);
        expectBundle(32'h108, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h107, 1'b0);
        checkOutput("redir_addr_a", imem_addr_a, 32'h104);
        checkOutput("redir_addr_b", imem_addr_b, 32'h108);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // fetch_en drop and resume
        expectBundle(32'h110, 1'b1);
        expectBundle(32'h118, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("resume_addr_a", imem_addr_a, 32'h118);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // fetch_en drop during hold keeps the bundle valid
        expectBundle(32'h120, 1'b1);
        expectBundle(32'h128, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("halt_hold_pc", out_pc, 32'h120);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("resume2_addr_a", imem_addr_a, 32'h128);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect kills ready bundles, drops a hold, then reset mid-hold
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        checkOutput("kill_addr_a", imem_addr_a, 32'h200);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("hold2_pc", out_pc, 32'h200);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        checkOutput("redir_hold_addr_a", imem_addr_a, 32'h300);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("hold3_pc", out_pc, 32'h300);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst_addr_a", imem_addr_a, 32'h0);
        checkOutput("midrst_addr_b", imem_addr_b, 32'h4);
        expectBundle(32'h00, 1'b1);
        expectBundle(32'h08, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Address wrap at the top of the 32-bit space
        expectBundle(32'hFFFF_FFFC, 1'b0);
        expectBundle(32'h0000_0000, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        checkOutput("wrap_addr_a", imem_addr_a, 32'hFFFF_FFFC);
        checkOutput("wrap_addr_b", imem_addr_b, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

`ifdef FETCH_RANGE_CHECK_EN
        expectBundle(32'h3FFC, 1'b0);
        expectBundle(32'h4000, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h3FFC, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("range_fault_last", 32'(out_fault), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("range_fault_beyond", 32'(out_fault), 32'd1);
`endif

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
